fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of each requester's data and of the FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, legal range 2..8: number of requesters.
REQ-003 SHALL have parameter BURST_LEN, default 4, legal range 1..256: maximum beats per grant.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ: bit i is requester i offering a beat.
REQ-007 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH: requester i's data sits in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready, output, NUM_REQ: bit i is the beat acceptance for requester i.
REQ-009 SHALL have port fifo_wr_data, output, DATA_WIDTH: data to the sync FIFO write port.
REQ-010 SHALL have port fifo_wr_en, output, 1: write strobe to the sync FIFO.
REQ-011 SHALL have port fifo_full, input, 1: full flag from the FIFO.
REQ-012 SHALL have port fifo_almost_full, input, 1: almost_full flag from the FIFO.
REQ-013 SHALL have port grant_id, output, clog2(NUM_REQ): the requester currently or last granted.
REQ-014 SHALL have port busy, output, 1: high while in state BURST.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BURST, plus registers rr_ptr, grant_id and beat_cnt.
REQ-016 In IDLE, if any req_valid bit is set and the arbiter is not blocked (see REQ-029), the block SHALL select the first set bit at or after rr_ptr, searching upward with wrap, latch it into grant_id, clear beat_cnt, and enter BURST on the next edge.
REQ-017 SHALL transfer no beats in IDLE; req_ready is all zero and fifo_wr_en is 0, giving one cycle of arbitration latency per grant.
REQ-018 In BURST, req_ready[grant_id] SHALL equal !fifo_full, and all other req_ready bits SHALL be 0.
REQ-019 A beat SHALL occur in any BURST cycle where req_valid[grant_id] is 1 and fifo_full is 0.
REQ-020 In a beat cycle, fifo_wr_en SHALL be 1 combinationally in the same cycle, with fifo_wr_data equal to req_data of grant_id; otherwise fifo_wr_en SHALL be 0 and fifo_wr_data SHALL be 0.
REQ-021 On each beat, beat_cnt SHALL increment; beat_cnt width is clog2(BURST_LEN)+1 and it never wraps.
REQ-022 BURST SHALL exit to IDLE after a beat taken with beat_cnt == BURST_LEN-1.
REQ-023 BURST SHALL also exit to IDLE in any cycle where req_valid[grant_id] is 0 (early release), regardless of fifo_full.
REQ-024 While fifo_full is 1 and req_valid[grant_id] is 1, the block SHALL hold BURST with beat_cnt unchanged, indefinitely, with no timeout.
REQ-025 On every BURST exit, rr_ptr SHALL load (grant_id+1) mod NUM_REQ; rr_ptr SHALL be unchanged otherwise.
REQ-026 req_valid changes on non-granted requesters SHALL have no effect during BURST; arbitration occurs only in IDLE.
REQ-027 With BURST_LEN=1, every grant SHALL be exactly one beat, giving a sustained throughput of one beat per two cycles.

Reset
REQ-028 While rst=1 at an edge, the block SHALL load state IDLE, rr_ptr 0, grant_id 0 and beat_cnt 0. This holds mid-burst too: the partial burst is abandoned, and beats already written stay in the FIFO. busy, req_ready, fifo_wr_en and fifo_wr_data SHALL read 0 from the cycle after that edge.

Configuration
REQ-029 Macro FIFO_WR_ARB_AF_THROTTLE_EN: when defined, IDLE SHALL NOT start a grant while fifo_almost_full is 1, and a burst already in progress continues, gated only by fifo_full. When undefined, fifo_almost_full SHALL be ignored (input unused).

Verification
REQ-030 Only req_valid[0]=1 held, BURST_LEN=4, fifo never full -> 8 fifo_wr_en pulses in the first 10 cycles after reset release, with IDLE cycles at cycles 0 and 5; grant_id stays 0.
REQ-031 req_valid=4'b1111 held -> grant_id sequence 0,1,2,3,0 with 4 beats each; each requester's data is written in order.
REQ-032 fifo_full=1 for 3 cycles after the 2nd beat of requester 1's burst -> req_ready[1]=0 and fifo_wr_en=0 for those 3 cycles, then beats 3 and 4 complete; 4 total writes.
REQ-033 Requester 2 granted drops req_valid after 2 beats -> IDLE next cycle, rr_ptr=3, and requester 3 is granted next if valid.
REQ-034 rst=1 pulsed during beat 2 of a burst -> the next cycle has busy=0, req_ready=0, fifo_wr_en=0, and the next grant starts searching from requester 0.
REQ-035 fifo_almost_full=1 with req_valid=4'b0001 -> with the macro, stays IDLE (busy=0); without it, grant 0 is issued and 4 beats are written.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bus between N write requesters, the arbiter and one sync FIFO write port.
// Handshake: a requester beat transfers on a rising edge where req_valid[i] && req_ready[i]; fifo_wr_en marks that same beat.
interface fifo_wr_arbiter_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          fifo_wr_en;
   logic                          fifo_full;
   logic                          fifo_almost_full;
   logic [ID_W-1:0]               grant_id;
   logic                          busy;

   modport master (
      input  req_valid, req_data, fifo_full, fifo_almost_full,
      output req_ready, fifo_wr_data, fifo_wr_en, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, fifo_full, fifo_almost_full,
      input  req_ready, fifo_wr_data, fifo_wr_en, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one sync FIFO write port; busy is the FSM state (IDLE=0, BURST=1).
// Optional macro FIFO_WR_ARB_AF_THROTTLE_EN: no new grant starts while fifo_almost_full is high.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int BURST_LEN  = 4
) (
   input logic                clk,
   input logic                rst,
   fifo_wr_arbiter_if.master  bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(BURST_LEN) + 1;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  rr_ptr, rr_nxt;
   logic [ID_W-1:0]  grant_id, gid_nxt;
   logic [CNT_W-1:0] beat_cnt, cnt_nxt;

   logic             pick_found;
   logic [ID_W-1:0]  pick_id;
   logic             blocked;
   logic             gvalid;
   logic             beat;
   logic             last_beat;
   logic             burst_exit;

`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
   assign blocked = bus.fifo_almost_full;
`else
   logic unused_af;
   assign unused_af = bus.fifo_almost_full;
   assign blocked   = 1'b0;
`endif

   assign gvalid     = bus.req_valid[grant_id];
   assign beat       = (state == BURST) && gvalid && !bus.fifo_full;
   assign last_beat  = beat && (beat_cnt == CNT_W'(BURST_LEN - 1));
   assign burst_exit = (state == BURST) && (!gvalid || last_beat);

   // Descending scan so the lowest offset from rr_ptr is the one left standing.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (bus.req_valid[ID_W'(idx)]) begin
            pick_found = 1'b1;
            pick_id    = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_nxt;
         grant_id <= gid_nxt;
         beat_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      gid_nxt   = grant_id;
      cnt_nxt   = beat_cnt;
      case (state)
         IDLE: begin
            if (pick_found && !blocked) begin
               state_nxt = BURST;
               gid_nxt   = pick_id;
               cnt_nxt   = '0;
            end
         end
         BURST: begin
            if (beat) cnt_nxt = beat_cnt + CNT_W'(1);
            if (burst_exit) begin
               state_nxt = IDLE;
               rr_nxt    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready    = '0;
      bus.fifo_wr_en   = 1'b0;
      bus.fifo_wr_data = '0;
      bus.busy         = (state == BURST);
      bus.grant_id     = grant_id;
      if (state == BURST) bus.req_ready[grant_id] = !bus.fifo_full;
      if (beat) begin
         bus.fifo_wr_en   = 1'b1;
         bus.fifo_wr_data = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, 16-bit data, 4-beat bursts).
// Requester i sources data {i, seq[i]} and advances seq[i] on each accepted beat.
module tb_fifo_wr_arbiter;
   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;
   int   fail_cnt;
   int   wr_cnt;
   logic [11:0] seq [4];

   fifo_wr_arbiter_if #(.DATA_WIDTH(16), .NUM_REQ(4)) bus ();

   fifo_wr_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .BURST_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_data();
      for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = {4'(i), seq[i]};
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid = '0;
      bus.fifo_full = 1'b0;
      bus.fifo_almost_full = 1'b0;
      for (int i = 0; i < 4; i++) seq[i] = '0;
      drive_data();
      wr_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock cycle: apply inputs, check outputs mid-cycle, then step past the next edge.
   task automatic run_cycle(input string tag, input logic r, input logic [3:0] v, input logic full,
                            input logic af, input logic eb, input logic ee, input logic [15:0] ed,
                            input int eg);
      logic [3:0] er;
      rst = r;
      bus.req_valid = v;
      bus.fifo_full = full;
      bus.fifo_almost_full = af;
      drive_data();
      #1;
      er = (eb && !full) ? (4'b0001 << eg) : 4'b0000;
      chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
      chk({tag, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(ee));
      chk({tag, ".wr_data"}, 32'(bus.fifo_wr_data), 32'(ed));
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'(er));
      if (eg >= 0) chk({tag, ".gid"}, 32'(bus.grant_id), 32'(eg));
      if (bus.fifo_wr_en === 1'b1) wr_cnt++;
      for (int i = 0; i < 4; i++) if (v[i] && bus.req_ready[i] === 1'b1) seq[i]++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      fail_cnt = 0;

      // Single requester held: bursts at cycles 1-4 and 6-9.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c % 5 == 0)
            run_cycle($sformatf("A%0d", c), 0, 4'b0001, 0, 0, 0, 0, 16'h0, 0);
         else
            run_cycle($sformatf("A%0d", c), 0, 4'b0001, 0, 0, 1, 1,
                      {4'd0, 12'((c/5)*4 + c%5 - 1)}, 0);
      end
      chk("A.writes", 32'(wr_cnt), 32'd8);

      // All requesting: grants rotate 0,1,2,3,0 with four in-order beats each.
      do_reset();
      for (int c = 0; c < 25; c++) begin
         if (c % 5 == 0)
            run_cycle($sformatf("B%0d", c), 0, 4'b1111, 0, 0, 0, 0, 16'h0,
                      (c == 0) ? 0 : ((c/5) - 1) % 4);
         else
            run_cycle($sformatf("B%0d", c), 0, 4'b1111, 0, 0, 1, 1,
                      {4'((c/5) % 4), 12'((c/20)*4 + c%5 - 1)}, (c/5) % 4);
      end
      chk("B.writes", 32'(wr_cnt), 32'd20);

      // FIFO full for three cycles after requester 1's second beat.
      do_reset();
      run_cycle("C0", 0, 4'b0010, 0, 0, 0, 0, 16'h0, 0);
      run_cycle("C1", 0, 4'b0010, 0, 0, 1, 1, 16'h1000, 1);
      run_cycle("C2", 0, 4'b0010, 0, 0, 1, 1, 16'h1001, 1);
      run_cycle("C3", 0, 4'b0010, 1, 0, 1, 0, 16'h0, 1);
      run_cycle("C4", 0, 4'b0010, 1, 0, 1, 0, 16'h0, 1);
      run_cycle("C5", 0, 4'b0010, 1, 0, 1, 0, 16'h0, 1);
      run_cycle("C6", 0, 4'b0010, 0, 0, 1, 1, 16'h1002, 1);
      run_cycle("C7", 0, 4'b0010, 0, 0, 1, 1, 16'h1003, 1);
      run_cycle("C8", 0, 4'b0000, 0, 0, 0, 0, 16'h0, 1);
      chk("C.writes", 32'(wr_cnt), 32'd4);

      // Requester 2 releases early; rr_ptr=3 makes requester 3 win over requester 0.
      do_reset();
      run_cycle("D0", 0, 4'b0100, 0, 0, 0, 0, 16'h0, 0);
      run_cycle("D1", 0, 4'b0101, 0, 0, 1, 1, 16'h2000, 2);
      run_cycle("D2", 0, 4'b0101, 0, 0, 1, 1, 16'h2001, 2);
      run_cycle("D3", 0, 4'b1001, 0, 0, 1, 0, 16'h0, 2);
      run_cycle("D4", 0, 4'b1001, 0, 0, 0, 0, 16'h0, 2);
      run_cycle("D5", 0, 4'b1001, 0, 0, 1, 1, 16'h3000, 3);
      run_cycle("D6", 0, 4'b1001, 0, 0, 1, 1, 16'h3001, 3);
      run_cycle("D7", 0, 4'b1001, 0, 0, 1, 1, 16'h3002, 3);
      run_cycle("D8", 0, 4'b1001, 0, 0, 1, 1, 16'h3003, 3);
      run_cycle("D9", 0, 4'b1001, 0, 0, 0, 0, 16'h0, 3);
      run_cycle("D10", 0, 4'b1001, 0, 0, 1, 1, 16'h0000, 0);

      // Reset mid-burst after rr_ptr has moved to 3; next search restarts at 0.
      do_reset();
      run_cycle("E0", 0, 4'b0100, 0, 0, 0, 0, 16'h0, 0);
      for (int c = 1; c < 5; c++)
         run_cycle($sformatf("E%0d", c), 0, 4'b0100, 0, 0, 1, 1, {4'd2, 12'(c - 1)}, 2);
      run_cycle("E5", 0, 4'b1000, 0, 0, 0, 0, 16'h0, 2);
      run_cycle("E6", 0, 4'b1000, 0, 0, 1, 1, 16'h3000, 3);
      run_cycle("E7", 1, 4'b1000, 0, 0, 1, 1, 16'h3001, 3);
      run_cycle("E8", 0, 4'b1001, 0, 0, 0, 0, 16'h0, 0);
      run_cycle("E9", 0, 4'b1001, 0, 0, 1, 1, 16'h0000, 0);

      // Almost-full at grant time.
      do_reset();
`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
      for (int c = 0; c < 4; c++)
         run_cycle($sformatf("F%0d", c), 0, 4'b0001, 0, 1, 0, 0, 16'h0, 0);
      run_cycle("F4", 0, 4'b0001, 0, 0, 0, 0, 16'h0, 0);
      run_cycle("F5", 0, 4'b0001, 0, 0, 1, 1, 16'h0000, 0);
      chk("F.writes", 32'(wr_cnt), 32'd1);
`else
      run_cycle("F0", 0, 4'b0001, 0, 1, 0, 0, 16'h0, 0);
      for (int c = 1; c < 5; c++)
         run_cycle($sformatf("F%0d", c), 0, 4'b0001, 0, 1, 1, 1, {4'd0, 12'(c - 1)}, 0);
      run_cycle("F5", 0, 4'b0000, 0, 1, 0, 0, 16'h0, 0);
      chk("F.writes", 32'(wr_cnt), 32'd4);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
